// File: rtl/cva6_trace_pkg.sv
// Shared constants and width helpers for the commit-trace capture buffer.
package cva6_trace_pkg;

  localparam int INSN_W     = 32;
  localparam int CAUSE_W    = 8;
  localparam int PRIV_W     = 3;
  localparam int DROP_CNT_W = 32;

  // Record layout MSB first: tval, cause, interrupt, exception, priv, insn, iaddr.
  function automatic int rec_width(input int iaddr_w, input int tval_w);
    return tval_w + CAUSE_W + 1 + 1 + PRIV_W + INSN_W + iaddr_w;
  endfunction

  function automatic int port_width(input int nr_ports);
    return (nr_ports > 1) ? $clog2(nr_ports) : 1;
  endfunction

endpackage

// File: rtl/cva6_trace_buffer_if.sv
// Commit-side trace inputs and valid/ready record output of the trace buffer.
// slave = the buffer, master = the core/bridge side driving it.
interface cva6_trace_buffer_if
  import cva6_trace_pkg::*;
#(
  parameter int NR_PORTS = 2,
  parameter int IADDR_W  = 40,
  parameter int TVAL_W   = 40,
  parameter int DEPTH    = 8
);
  localparam int REC_W  = rec_width(IADDR_W, TVAL_W);
  localparam int PORT_W = port_width(NR_PORTS);
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic                          flush_i;
  logic [NR_PORTS-1:0]           valid_i;
  logic [NR_PORTS*IADDR_W-1:0]   iaddr_i;
  logic [NR_PORTS*INSN_W-1:0]    insn_i;
  logic [NR_PORTS*2-1:0]         priv_i;
  logic [NR_PORTS-1:0]           exception_i;
  logic [NR_PORTS-1:0]           interrupt_i;
  logic [NR_PORTS*CAUSE_W-1:0]   cause_i;
  logic [NR_PORTS*TVAL_W-1:0]    tval_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [REC_W-1:0]              out_rec_o;
  logic [PORT_W-1:0]             out_port_o;
  logic [LVL_W-1:0]              level_o;
  logic                          overflow_o;
  logic [DROP_CNT_W-1:0]         drop_cnt_o;

  modport slave (
    input  flush_i, valid_i, iaddr_i, insn_i, priv_i, exception_i, interrupt_i,
           cause_i, tval_i, out_ready_i,
    output out_valid_o, out_rec_o, out_port_o, level_o, overflow_o, drop_cnt_o
  );

  modport master (
    output flush_i, valid_i, iaddr_i, insn_i, priv_i, exception_i, interrupt_i,
           cause_i, tval_i, out_ready_i,
    input  out_valid_o, out_rec_o, out_port_o, level_o, overflow_o, drop_cnt_o
  );

endinterface

// File: rtl/cva6_trace_fifo.sv
// Circular buffer: up to NR_PORTS compacted writes and one read per cycle, 1-cycle write-to-output.
// Head entry is re-registered every cycle, so it stays stable while not popped and holds when empty.
module cva6_trace_fifo #(
  parameter int NR_PORTS = 2,
  parameter int DEPTH    = 8,
  parameter int DW       = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [NR_PORTS-1:0]      wmask_i,
  input  logic [NR_PORTS*DW-1:0]   wdat_i,
  input  logic                     pop_i,
  output logic                     out_valid_o,
  output logic [DW-1:0]            out_dat_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_dat;

  logic [DEPTH-1:0] w_we;
  logic [DW-1:0]    w_slot [DEPTH];
  logic [AW-1:0]    w_idx;
  logic [LW-1:0]    w_nwr;
  logic             w_pop;
  logic [AW-1:0]    w_rd_next;
  logic [LW-1:0]    w_level_next;

  // Valid ports are compacted onto consecutive slots; w_slot is the post-write storage view.
  always_comb begin
    w_we  = '0;
    w_idx = r_wr_ptr;
    w_nwr = '0;
    for (int s = 0; s < DEPTH; s++) w_slot[s] = r_mem[s];
    for (int p = 0; p < NR_PORTS; p++) begin
      if (push_i && !flush_i && wmask_i[p]) begin
        w_we[w_idx]   = 1'b1;
        w_slot[w_idx] = wdat_i[p*DW +: DW];
        w_idx         = w_idx + AW'(1);
        w_nwr         = w_nwr + LW'(1);
      end
    end
  end

  assign w_pop        = pop_i && r_out_valid;
  assign w_rd_next    = r_rd_ptr + AW'(w_pop);
  assign w_level_next = r_level + w_nwr - LW'(w_pop);

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (w_we[s]) r_mem[s] <= w_slot[s];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_dat   <= '0;
    end else if (flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_wr_ptr    <= w_idx;
      r_rd_ptr    <= w_rd_next;
      r_level     <= w_level_next;
      r_out_valid <= (w_level_next != '0);
      // Bypass through w_slot so a write into an empty buffer is visible after one edge.
      if (w_level_next != '0) r_out_dat <= w_slot[w_rd_next];
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_dat_o   = r_out_dat;
  assign level_o     = r_level;

endmodule

// File: rtl/cva6_trace_buffer.sv
// Commit-trace capture buffer: packs per-port records, accepts whole commit groups or drops them (counted).
// 1-cycle latency, one record/cycle out under valid/ready; optional counter via CVA6_TRACE_DROP_CNT_EN.
module cva6_trace_buffer
  import cva6_trace_pkg::*;
#(
  parameter int NR_PORTS = 2,
  parameter int IADDR_W  = 40,
  parameter int TVAL_W   = 40,
  parameter int DEPTH    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  cva6_trace_buffer_if.slave  bus
);
  localparam int REC_W  = rec_width(IADDR_W, TVAL_W);
  localparam int PORT_W = port_width(NR_PORTS);
  localparam int DW     = REC_W + PORT_W;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic [NR_PORTS*DW-1:0] w_wdat;
  logic [LVL_W-1:0]       w_n;
  logic [LVL_W-1:0]       w_level;
  logic [LVL_W-1:0]       w_space;
  logic                   w_fit;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_pop;
  logic                   w_out_valid;
  logic [DW-1:0]          w_out_dat;
  logic                   r_overflow;

  always_comb begin
    w_wdat = '0;
    w_n    = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      w_wdat[p*DW +: DW] = {PORT_W'(p),
                            bus.tval_i[p*TVAL_W +: TVAL_W],
                            bus.cause_i[p*CAUSE_W +: CAUSE_W],
                            bus.interrupt_i[p],
                            bus.exception_i[p],
                            {(PRIV_W-2){1'b0}}, bus.priv_i[p*2 +: 2],
                            bus.insn_i[p*INSN_W +: INSN_W],
                            bus.iaddr_i[p*IADDR_W +: IADDR_W]};
      w_n = w_n + LVL_W'(bus.valid_i[p]);
    end
  end

  // Space is judged on the registered level only; a same-cycle pop never makes room.
  assign w_space = LVL_W'(DEPTH) - w_level;
  assign w_fit   = (w_n <= w_space);
  assign w_push  = !bus.flush_i && (w_n != '0) && w_fit;
  assign w_drop  = !bus.flush_i && !w_fit;
  assign w_pop   = w_out_valid && bus.out_ready_i && !bus.flush_i;

  cva6_trace_fifo #(
    .NR_PORTS (NR_PORTS),
    .DEPTH    (DEPTH),
    .DW       (DW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (bus.flush_i),
    .push_i      (w_push),
    .wmask_i     (bus.valid_i),
    .wdat_i      (w_wdat),
    .pop_i       (w_pop),
    .out_valid_o (w_out_valid),
    .out_dat_o   (w_out_dat),
    .level_o     (w_level)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          r_overflow <= 1'b0;
    else if (bus.flush_i) r_overflow <= 1'b0;
    else if (w_drop)      r_overflow <= 1'b1;
  end

`ifdef CVA6_TRACE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic [DROP_CNT_W:0]   w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_drop_cnt} + (DROP_CNT_W+1)'(w_n);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          r_drop_cnt <= '0;
    else if (bus.flush_i) r_drop_cnt <= '0;
    else if (w_drop)      r_drop_cnt <= w_cnt_sum[DROP_CNT_W] ? '1 : w_cnt_sum[DROP_CNT_W-1:0];
  end

  assign bus.drop_cnt_o = r_drop_cnt;
`else
  assign bus.drop_cnt_o = '0;
`endif

  assign bus.out_valid_o = w_out_valid;
  assign bus.out_rec_o   = w_out_dat[REC_W-1:0];
  assign bus.out_port_o  = w_out_dat[DW-1 -: PORT_W];
  assign bus.level_o     = w_level;
  assign bus.overflow_o  = r_overflow;

endmodule
